// File: rtl/i2c_master.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP.
// SCL is push-pull; SDA is driven open-drain through sda_oe.
module i2c_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enb,
   input  logic       start,
   input  logic [6:0] addr,
   input  logic       rw,
   input  logic [7:0] data_wr,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       scl,
   output logic [7:0] data_rd,
   output logic       busy,
   output logic       done,
   output logic       nack
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_ADDR,
      ST_ACK1,
      ST_DATA,
      ST_ACK2,
      ST_STOP
   } state_t;

   state_t           state, state_n;
   logic [DIV_W-1:0] div_cnt, div_n;
   logic [1:0]       q, q_n;
   logic [2:0]       bit_cnt, bit_n;
   logic [7:0]       frame, frame_n;
   logic [7:0]       wbyte, wbyte_n;
   logic [7:0]       data_rd_n;
   logic             scl_n, sda_oe_n, busy_n, done_n, nack_n;
   logic             tick, slot_end, sample;

   // Quarter tick, end of a bit slot, and the q2->q3 SDA sample point.
   assign tick     = (state != ST_IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
   assign slot_end = tick && (q == 2'd3);
   assign sample   = tick && (q == 2'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         div_cnt <= '0;
         q       <= '0;
         bit_cnt <= '0;
         frame   <= '0;
         wbyte   <= '0;
         scl     <= 1'b1;
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         nack    <= 1'b0;
         data_rd <= '0;
      end else begin
         state   <= state_n;
         div_cnt <= div_n;
         q       <= q_n;
         bit_cnt <= bit_n;
         frame   <= frame_n;
         wbyte   <= wbyte_n;
         scl     <= scl_n;
         sda_oe  <= sda_oe_n;
         busy    <= busy_n;
         done    <= done_n;
         nack    <= nack_n;
         data_rd <= data_rd_n;
      end
   end

   always_comb begin
      state_n   = state;
      div_n     = div_cnt;
      q_n       = q;
      bit_n     = bit_cnt;
      frame_n   = frame;
      wbyte_n   = wbyte;
      busy_n    = busy;
      done_n    = 1'b0;
      nack_n    = nack;
      data_rd_n = data_rd;
      scl_n     = 1'b1;
      sda_oe_n  = 1'b0;

      if (state != ST_IDLE) begin
         div_n = tick ? DIV_W'(0) : div_cnt + DIV_W'(1);
         if (tick) q_n = q + 2'd1;
      end

      unique case (state)
         ST_IDLE: begin
            // done blocks accept so a request in the DONE cycle is dropped
            if (enb && start && !done) begin
               state_n = ST_START;
               div_n   = '0;
               q_n     = '0;
               bit_n   = '0;
               frame_n = {addr, rw};
               wbyte_n = data_wr;
               nack_n  = 1'b0;
               busy_n  = 1'b1;
            end
         end
         ST_START: begin
            if (slot_end) begin
               state_n = ST_ADDR;
               bit_n   = '0;
            end
         end
         ST_ADDR: begin
            if (slot_end) begin
               if (bit_cnt == 3'd7) state_n = ST_ACK1;
               bit_n = bit_cnt + 3'd1;
            end
         end
         ST_ACK1: begin
            if (sample && sda_in) nack_n = 1'b1;
            if (slot_end) state_n = nack ? ST_STOP : ST_DATA;
         end
         ST_DATA: begin
            if (sample && frame[0]) data_rd_n = {data_rd[6:0], sda_in};
            if (slot_end) begin
               if (bit_cnt == 3'd7) state_n = ST_ACK2;
               bit_n = bit_cnt + 3'd1;
            end
         end
         ST_ACK2: begin
            if (sample && !frame[0] && sda_in) nack_n = 1'b1;
            if (slot_end) state_n = ST_STOP;
         end
         ST_STOP: begin
            if (slot_end) begin
               state_n = ST_IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
         end
      endcase

      // Line levels are decoded from the next state so the registered pins line up with it.
      unique case (state_n)
         ST_IDLE: begin
            scl_n    = 1'b1;
            sda_oe_n = 1'b0;
         end
         ST_START: begin
            scl_n    = 1'b1;
            sda_oe_n = q_n[1];
         end
         ST_ADDR: begin
            scl_n    = q_n[1];
            sda_oe_n = ~frame_n[3'd7 - bit_n];
         end
         ST_DATA: begin
            scl_n    = q_n[1];
            sda_oe_n = frame_n[0] ? 1'b0 : ~wbyte_n[3'd7 - bit_n];
         end
         ST_ACK1, ST_ACK2: begin
            scl_n    = q_n[1];
            sda_oe_n = 1'b0;
         end
         ST_STOP: begin
            scl_n    = (q_n != 2'd0);
            sda_oe_n = ~q_n[1];
         end
         default: begin
            scl_n    = 1'b1;
            sda_oe_n = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C bus master that generates START, a 7-bit address plus R/W bit, one data byte (write or read) and STOP on SCL/SDA. It replaces the hand-timed stimulus that currently drives the I2C slave, so that the slave can be exercised from a synchronous host interface. It sits directly upstream of the slave on the shared open-drain SDA line.

## Interface
- CLK_DIV, 4, system clocks per SCL quarter-period (>=2); one bit slot = 4*CLK_DIV clocks
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- ENB  in  1  enable; START is accepted only while ENB=1
- START  in  1  request a transfer; sampled only in IDLE
- ADDR  in  7  slave address, latched on accept
- RW  in  1  1=read, 0=write; latched on accept
- DATA_WR  in  8  write byte; latched on accept
- SDA_IN  in  1  resolved SDA line level (pull-up high)
- SDA_OE  out  1  1=pull SDA low; 0=release (line reads 1)
- SCL  out  1  SCL, push-pull, no clock stretching
- DATA_RD  out  8  byte received on read; valid when DONE=1
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle pulse at transfer end
- NACK  out  1  slave NACKed address or write byte; held until next accept

## Operation
- States: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP.
- A quarter tick fires every CLK_DIV clocks while BUSY. Each state occupies whole bit slots of 4 quarters q0..q3.
- Data/ACK slot: q0,q1 SCL=0, SDA updated at start of q0; q2,q3 SCL=1; SDA_IN sampled at the q2->q3 boundary.
- START slot: q0,q1 SCL=1 SDA released; q2,q3 SCL=1 SDA low. The falling SDA edge with SCL high is the START condition.
- ADDR: 8 slots, MSB first, ADDR[6:0] then RW. A 1 bit is sent by releasing (SDA_OE=0), a 0 bit by SDA_OE=1.
- ACK1: SDA released; sampled 0 = ACK, 1 = NACK. On NACK, NACK=1 and the FSM goes directly to STOP.
- DATA, write: 8 slots carrying DATA_WR MSB first.
- DATA, read: SDA released for all 8 slots; the sampled bits shift MSB first into DATA_RD.
- ACK2, write: SDA released; a sampled 1 sets NACK=1.
- ACK2, read: the master releases SDA (NACK, single-byte read).
- STOP slot: q0 SCL=0 SDA low; q1 SCL=1 SDA low; q2,q3 SCL=1 SDA released. The rising SDA edge with SCL high is the STOP condition.
- After the STOP slot: BUSY=0, DONE=1 for one cycle, then IDLE.
- In IDLE: SCL=1, SDA_OE=0.

## Timing
- Reset values: SCL=1, SDA_OE=0, BUSY=0, DONE=0, NACK=0, DATA_RD=8'h00, state IDLE, quarter counter 0.
- Accept: edge where IDLE & ENB & START. ADDR/RW/DATA_WR are latched and NACK is cleared. BUSY=1 and the START slot q0 begin the next cycle.
- Full transfer: 20 slots = 80*CLK_DIV clocks from the accept edge to the DONE pulse.
- Address-NACK transfer: 11 slots = 44*CLK_DIV clocks.
- START pulses while BUSY or DONE=1 are ignored; there is no queueing.
- ENB is checked only at accept. Dropping ENB mid-transfer has no effect on the transfer in progress.
- DATA_RD changes only during a read DATA state. It holds its value after DONE until the next read.
- RESET mid-transfer: all outputs take their reset values immediately (asynchronous). SDA is released, SCL=1 and no STOP is generated.
- SDA never changes while SCL=1, except in the START and STOP slots.

## Test plan
- Write, CLK_DIV=2, ADDR=7'h54, RW=0, DATA_WR=8'hB8, slave ACKs both slots -> SDA levels at SCL rises are 1010100,0 then 10111000. DONE pulses 160 clocks after accept; NACK=0.
- Read, ADDR=7'h60, RW=1, slave drives 8'hBE in DATA slots -> DATA_RD=8'hBE at DONE. SDA_OE=0 throughout the DATA and ACK2 slots.
- Address NACK: slave leaves ACK1 high -> NACK=1 and STOP immediately follows ACK1. DONE arrives 88 clocks (CLK_DIV=2) after accept. NACK stays 1 until the next accept.
- Write-data NACK: SDA=1 in ACK2 -> NACK=1, normal STOP, DONE at 160 clocks.
- RESET asserted during DATA bit 3 -> same cycle SCL=1, SDA_OE=0, BUSY=0. A new START after release runs a full transfer correctly.
- Gating: START with ENB=0 -> BUSY stays 0. A second START pulse mid-transfer -> no effect; exactly one DONE is produced.
